// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_e;

    // Op bit 1 selects divide, bit 0 selects unsigned.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_if.sv
// Handshake, operand and HI/LO bus of the multiply/divide unit.
interface mdu_if #(parameter int WIDTH = 32);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wr_data,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wr_data,
        output busy, done, div_zero, hi, lo
    );

endinterface

// File: rtl/mdu_negate.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module mdu_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic             neg,
    output logic [WIDTH-1:0] out
);

    assign out = neg ? (~in + WIDTH'(1)) : in;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; one result bit per cycle.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    mdu_if.slave  bus
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e         state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] work;      // multiply: {acc, multiplier}; divide: {remainder, quotient}
    logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
    logic               is_div;
    logic               res_neg;   // product / quotient sign
    logic               rem_neg;   // remainder follows the dividend sign
    logic               dz;
    logic               busy_q;
    logic               done_q;
    logic               dz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    // Operand magnitudes for signed ops.
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    assign a_neg = op_is_signed(bus.op) & bus.a[WIDTH-1];
    assign b_neg = op_is_signed(bus.op) & bus.b[WIDTH-1];

    mdu_negate #(.WIDTH(WIDTH)) u_abs_a (.in(bus.a), .neg(a_neg), .out(a_abs));
    mdu_negate #(.WIDTH(WIDTH)) u_abs_b (.in(bus.b), .neg(b_neg), .out(b_abs));

    // One shift-add multiply step: add multiplicand when the low multiplier bit is set,
    // then shift the whole {carry, acc, multiplier} right by one.
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mul_next;

    assign add_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : '0);
    assign mul_next = {add_sum, work[WIDTH-1:1]};

    // One restoring divide step: shift the next dividend bit into the remainder,
    // keep the subtraction only if it did not borrow.
    logic [WIDTH:0]     div_trial;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;

    assign div_trial = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    assign div_diff  = div_trial - {1'b0, opnd};
    assign div_next  = div_diff[WIDTH]
                     ? {div_trial[WIDTH-1:0], work[WIDTH-2:0], 1'b0}
                     : {div_diff[WIDTH-1:0],  work[WIDTH-2:0], 1'b1};

    // Result sign fix-up; the product is negated across the full double width.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    mdu_negate #(.WIDTH(2*WIDTH)) u_fix_prod (.in(work), .neg(res_neg), .out(prod_fix));
    mdu_negate #(.WIDTH(WIDTH)) u_fix_quo (.in(work[WIDTH-1:0]), .neg(res_neg), .out(quo_fix));
    mdu_negate #(.WIDTH(WIDTH)) u_fix_rem (.in(work[2*WIDTH-1:WIDTH]), .neg(rem_neg), .out(rem_fix));

    // Control FSM with registered handshake outputs and HI/LO ownership.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            work    <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            dz      <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        is_div  <= op_is_div(bus.op);
                        res_neg <= a_neg ^ b_neg;
                        rem_neg <= a_neg;
                        count   <= '0;
                        busy_q  <= 1'b1;
                        if (op_is_div(bus.op)) begin
                            work <= {{WIDTH{1'b0}}, a_abs};
                            opnd <= b_abs;
                        end else begin
                            work <= {{WIDTH{1'b0}}, b_abs};
                            opnd <= a_abs;
                        end
                        // A zero divisor skips the iterations entirely.
                        if (op_is_div(bus.op) && (bus.b == '0)) begin
                            dz    <= 1'b1;
                            state <= ST_FIX;
                        end else begin
                            dz    <= 1'b0;
                            state <= ST_RUN;
                        end
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wr_data;
                        if (bus.lo_we) lo_q <= bus.wr_data;
                    end
                end
                ST_RUN: begin
                    work  <= is_div ? div_next : mul_next;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) state <= ST_FIX;
                end
                ST_FIX: begin
                    if (!dz) begin
                        if (is_div) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                    end
                    done_q <= 1'b1;
                    dz_q   <= dz;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit at WIDTH=32.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mdu_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one op (edge 0 is the first edge after this call) and wait for Done.
    // lat = edge index at which Done was seen, -1 on timeout.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cycles, output int lat, output logic dz,
                          output logic held);
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = bus.hi;
        l0 = bus.lo;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start   = 1'b0;
        busy_cycles = 0;
        lat         = -1;
        dz          = 1'b0;
        held        = 1'b1;
        for (int e = 0; e < 100; e++) begin
            if (bus.done) begin
                lat = e;
                dz  = bus.div_zero;
                break;
            end
            if (bus.busy) begin
                busy_cycles++;
                if (bus.hi !== h0 || bus.lo !== l0) held = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
        checks++; if (bus.div_zero !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b want=0", bus.div_zero); end
        checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h want=0", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h want=0", bus.lo); end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mult();
        int bc, lat; logic dz, held;
        run_op(OP_MULT, 32'hFFFFFFFD, 32'h7, bc, lat, dz, held);
        checks++; if (lat != 33) begin failures++; $display("FAIL mult_latency got=%0d want=33", lat); end
        checks++; if (bc != 33) begin failures++; $display("FAIL mult_busy_cycles got=%0d want=33", bc); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mult_busy_in_done got=%b want=0", bus.busy); end
        checks++; if (bus.hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h want=FFFFFFFF", bus.hi); end
        checks++; if (bus.lo !== 32'hFFFFFFEB) begin failures++; $display("FAIL mult_lo got=%h want=FFFFFFEB", bus.lo); end
        checks++; if (dz !== 1'b0) begin failures++; $display("FAIL mult_dz got=%b want=0", dz); end
        checks++; if (held !== 1'b1) begin failures++; $display("FAIL mult_hilo_held got=%b want=1", held); end
        tick();
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL mult_done_pulse got=%b want=0", bus.done); end
    endtask

    task automatic test_multu();
        int bc, lat; logic dz, held;
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, lat, dz, held);
        checks++; if (lat != 33) begin failures++; $display("FAIL multu_latency got=%0d want=33", lat); end
        checks++; if (bus.hi !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_hi got=%h want=FFFFFFFE", bus.hi); end
        checks++; if (bus.lo !== 32'h00000001) begin failures++; $display("FAIL multu_lo got=%h want=00000001", bus.lo); end
    endtask

    task automatic test_div();
        int bc, lat; logic dz, held;
        run_op(OP_DIV, 32'hFFFFFFF9, 32'h2, bc, lat, dz, held);
        checks++; if (lat != 33) begin failures++; $display("FAIL div_latency got=%0d want=33", lat); end
        checks++; if (bus.lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h want=FFFFFFFD", bus.lo); end
        checks++; if (bus.hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h want=FFFFFFFF", bus.hi); end
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, bc, lat, dz, held);
        checks++; if (bus.lo !== 32'h80000000) begin failures++; $display("FAIL div_ovf_lo got=%h want=80000000", bus.lo); end
        checks++; if (bus.hi !== 32'h00000000) begin failures++; $display("FAIL div_ovf_hi got=%h want=00000000", bus.hi); end
        checks++; if (dz !== 1'b0) begin failures++; $display("FAIL div_ovf_dz got=%b want=0", dz); end
        run_op(OP_DIVU, 32'd100, 32'd7, bc, lat, dz, held);
        checks++; if (bus.lo !== 32'd14) begin failures++; $display("FAIL divu_lo got=%h want=0000000E", bus.lo); end
        checks++; if (bus.hi !== 32'd2) begin failures++; $display("FAIL divu_hi got=%h want=00000002", bus.hi); end
    endtask

    task automatic test_direct_write();
        bus.wr_data = 32'hDEADBEEF;
        bus.hi_we   = 1'b1;
        tick();
        bus.hi_we = 1'b0;
        checks++; if (bus.hi !== 32'hDEADBEEF) begin failures++; $display("FAIL mthi_hi got=%h want=DEADBEEF", bus.hi); end
        checks++; if (bus.lo !== 32'd14) begin failures++; $display("FAIL mthi_lo_kept got=%h want=0000000E", bus.lo); end
        bus.wr_data = 32'h12345678;
        bus.hi_we   = 1'b1;
        bus.lo_we   = 1'b1;
        tick();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        checks++; if (bus.hi !== 32'h12345678) begin failures++; $display("FAIL mthilo_hi got=%h want=12345678", bus.hi); end
        checks++; if (bus.lo !== 32'h12345678) begin failures++; $display("FAIL mthilo_lo got=%h want=12345678", bus.lo); end
    endtask

    task automatic test_div_zero();
        int bc, lat; logic dz, held;
        run_op(OP_DIVU, 32'd7, 32'd0, bc, lat, dz, held);
        checks++; if (lat != 1) begin failures++; $display("FAIL dz_latency got=%0d want=1", lat); end
        checks++; if (dz !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b want=1", dz); end
        checks++; if (bus.hi !== 32'h12345678) begin failures++; $display("FAIL dz_hi got=%h want=12345678", bus.hi); end
        checks++; if (bus.lo !== 32'h12345678) begin failures++; $display("FAIL dz_lo got=%h want=12345678", bus.lo); end
        tick();
        checks++; if (bus.div_zero !== 1'b0) begin failures++; $display("FAIL dz_pulse got=%b want=0", bus.div_zero); end
    endtask

    // MULTU 5x6 with a stray DIVU start at edge 10 and a HiWe at edge 12.
    task automatic test_ignored_while_busy();
        int lat;
        bus.op    = OP_MULTU;
        bus.a     = 32'd5;
        bus.b     = 32'd6;
        bus.start = 1'b1;
        tick();                       // edge 0
        bus.start = 1'b0;
        repeat (9) tick();            // edge 9
        bus.op    = OP_DIVU;
        bus.a     = 32'd100;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        tick();                       // edge 10
        bus.start = 1'b0;
        tick();                       // edge 11
        bus.wr_data = 32'hAAAA5555;
        bus.hi_we   = 1'b1;
        tick();                       // edge 12
        bus.hi_we = 1'b0;
        checks++; if (bus.hi !== 32'h12345678) begin failures++; $display("FAIL busy_hiwe_hi got=%h want=12345678", bus.hi); end
        lat = -1;
        for (int e = 12; e < 100; e++) begin
            if (bus.done) begin lat = e; break; end
            tick();
        end
        checks++; if (lat != 33) begin failures++; $display("FAIL busy_start_latency got=%0d want=33", lat); end
        checks++; if (bus.lo !== 32'h1E) begin failures++; $display("FAIL busy_start_lo got=%h want=0000001E", bus.lo); end
        checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL busy_start_hi got=%h want=00000000", bus.hi); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_start_relaunch got=%b want=0", bus.busy); end
    endtask

    task automatic test_reset_abort();
        logic seen;
        bus.wr_data = 32'h0F0F0F0F;
        bus.hi_we   = 1'b1;
        bus.lo_we   = 1'b1;
        tick();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.op    = OP_MULTU;
        bus.a     = 32'd5;
        bus.b     = 32'd6;
        bus.start = 1'b1;
        tick();                       // edge 0
        bus.start = 1'b0;
        repeat (19) tick();           // edge 19
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%b want=1", bus.busy); end
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
        checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL abort_hi got=%h want=0", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL abort_lo got=%h want=0", bus.lo); end
        tick();                       // edge 20
        rst  = 1'b0;
        seen = 1'b0;
        for (int e = 0; e < 40; e++) begin
            if (bus.done || bus.busy) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b want=0", seen); end
        checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL abort_lo_after got=%h want=0", bus.lo); end
    endtask

    // Second Start issued in the Done cycle of the first op.
    task automatic test_back_to_back();
        int bc, lat; logic dz, held;
        run_op(OP_MULTU, 32'd3, 32'd4, bc, lat, dz, held);
        checks++; if (bus.lo !== 32'hC) begin failures++; $display("FAIL b2b_first_lo got=%h want=0000000C", bus.lo); end
        run_op(OP_DIV, 32'd100, 32'hFFFFFFF9, bc, lat, dz, held);
        checks++; if (lat != 33) begin failures++; $display("FAIL b2b_latency got=%0d want=33", lat); end
        checks++; if (bus.lo !== 32'hFFFFFFF2) begin failures++; $display("FAIL b2b_lo got=%h want=FFFFFFF2", bus.lo); end
        checks++; if (bus.hi !== 32'h2) begin failures++; $display("FAIL b2b_hi got=%h want=00000002", bus.hi); end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.a       = '0;
        bus.b       = '0;
        bus.hi_we   = 1'b0;
        bus.lo_we   = 1'b0;
        bus.wr_data = '0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_direct_write();
        test_div_zero();
        test_ignored_while_busy();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative, WIDTH-parametrised multiply/divide unit owning the HI/LO register pair. It is the multi-cycle successor to the single-cycle ALU multiply/divide and HiLo register path in the MIPS datapath. It executes MULT/MULTU/DIV/DIVU one bit per cycle behind a Start/Busy/Done handshake and supports direct HI/LO writes for MTHI/MTLO. The top-level PC stall logic holds the pipeline while Busy is high.

## Interface
- WIDTH, 32, operand and HI/LO width; any value ≥ 4.
- Clk  in  1  system clock; all state updates on rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Start  in  1  launch operation; sampled only when Busy=0.
- Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start.
- A  in  WIDTH  multiplicand / dividend; sampled with Start.
- B  in  WIDTH  multiplier / divisor; sampled with Start.
- HiWe  in  1  direct HI write (MTHI).
- LoWe  in  1  direct LO write (MTLO).
- WrData  in  WIDTH  data for HiWe/LoWe.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle completion pulse.
- DivZero  out  1  one-cycle pulse with Done when the divisor was zero.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE + Start: latch the operands into internal registers. For signed ops, convert the operands to absolute values and record the result signs.
  - Next state is RUN with count=0.
- Exception: DIV/DIVU with B=0 goes straight to FIX with the DivZero flag set.
- RUN, multiply: shift-add on the {acc, multiplier} 2·WIDTH register.
- RUN, divide: restoring shift-subtract, producing one quotient bit per cycle.
- RUN leaves for FIX after WIDTH iterations (count = WIDTH−1).
- FIX, normal ops:
  - Conditionally negate the results.
  - Write {Hi,Lo} = product, or Lo = quotient, Hi = remainder.
  - Pulse Done and return to IDLE.
- FIX, divide by zero: Hi and Lo are unchanged; Done and DivZero pulse together.
- Sign rules:
  - Product is negative iff the operand signs differ; negation is 2·WIDTH-bit two's complement.
  - Quotient is negative iff the signs differ; the remainder takes the dividend's sign (truncating division).
- Overflow: signed MIN / −1 gives Lo=MIN, Hi=0. No flag.
- Direct writes:
  - HiWe/LoWe update Hi/Lo on the edge only when Busy=0 and Start=0; otherwise they are ignored.
  - HiWe and LoWe together write both registers.
- Start while Busy=1 is ignored; operands are not relatched.

## Timing
- Reset values: Busy=0, Done=0, DivZero=0, Hi=0, Lo=0; state IDLE; count 0.
- Start sampled at edge 0:
  - Busy=1 from edge 0 through edge WIDTH+1.
  - Result is written at edge WIDTH+1.
  - Done=1 for the cycle following edge WIDTH+1, with Busy=0 in the same cycle.
  - Latency is therefore WIDTH+1 edges (33 for WIDTH=32).
- Divide by zero: Done/DivZero are high after edge 1; latency 1.
- Back-to-back: a Start in the Done cycle is accepted, giving no bubble.
- Hi/Lo hold their old values throughout RUN and change only at the FIX edge.
- Rst asserted mid-operation aborts at once: outputs go to their reset values and no Done is issued.

## Structure
- Package mdu_pkg holds:
  - Op encoding localparams (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU).
  - State encoding (ST_IDLE, ST_RUN, ST_FIX).
- One sub-module, mdu_negate: a WIDTH-parametrised conditional two's-complement negate with ports In, Neg, Out.
  - Used for operand absolute values and result fix-up.
  - The product fix-up instantiates it at 2·WIDTH.
- Counter width is $clog2(WIDTH).

## Test plan
All cases use WIDTH=32.
- MULT A=FFFFFFFD (−3), B=7 → after 33 edges, Done=1, Hi=FFFFFFFF, Lo=FFFFFFEB; Busy high for exactly 33 cycles.
- MULTU A=FFFFFFFF, B=FFFFFFFF → Hi=FFFFFFFE, Lo=00000001.
- DIV A=FFFFFFF9 (−7), B=2 → Lo=FFFFFFFD (−3), Hi=FFFFFFFF (−1).
- DIV A=80000000, B=FFFFFFFF → Lo=80000000, Hi=00000000, DivZero=0.
- DIVU A=7, B=0 with Hi=Lo=12345678 preloaded via HiWe/LoWe → Done and DivZero high after 1 edge; Hi/Lo still 12345678.
- MULTU 5×6 running:
  - Second Start (DIVU) at edge 10 and HiWe with WrData=AAAA5555 at edge 12 are both ignored.
  - Result Lo=1E, Hi=0.
  - Repeat with Rst pulsed at edge 20: Hi=Lo=0, Busy=0, no Done.
